div_unit: RTL and testbench

//  Multi-cycle radix-2 restoring divider for DIV/DIVU, upstream of the HI/LO register.
//  EX asserts start_i with operands and stalls until ready_o. The 2*WIDTH result
//  {remainder, quotient} then flows down the pipeline: upper half to HI, lower half to LO.

---
 rtl/div_unit.sv | 141 ++++++++++++++
 tb/tb_div_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Produces {remainder, quotient} for the HI/LO write-back path.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH:0]   work_q, work_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH-1:0]   quo, rem;

    assign result_o = result_q;
    assign ready_o  = ready_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        dvsr_d   = dvsr_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        ready_d  = ready_q;
        mag1 = opdata1_i;
        mag2 = opdata2_i;
        if (signed_div_i && opdata1_i[WIDTH-1])
            mag1 = -opdata1_i;
        if (signed_div_i && opdata2_i[WIDTH-1])
            mag2 = -opdata2_i;
        diff = work_q[2*WIDTH:WIDTH] - {1'b0, dvsr_q};
        quo  = qneg_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
        rem  = rneg_q ? -work_q[2*WIDTH:WIDTH+1]
                      : work_q[2*WIDTH:WIDTH+1];
        case (state_q)
            IDLE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = BYZERO;
                    end else begin
                        state_d = ON;
                        cnt_d   = '0;
                        work_d  = {{WIDTH{1'b0}}, mag1, 1'b0};
                        dvsr_d  = mag2;
                        qneg_d  = signed_div_i &
                                  (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        rneg_d  = signed_div_i & opdata1_i[WIDTH-1];
                    end
                end
            end
            BYZERO: begin
                result_d = '0;
                if (annul_i) begin
                    state_d = IDLE;
                    ready_d = 1'b0;
                end else begin
                    state_d = END;
                    ready_d = 1'b1;
                end
            end
            ON: begin
                if (annul_i) begin
                    state_d  = IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else if (cnt_q != CNT_MAX) begin
                    // A negative trial difference means the divisor didn't fit.
                    if (diff[WIDTH])
                        work_d = {work_q[2*WIDTH-1:0], 1'b0};
                    else
                        work_d = {diff[WIDTH-1:0], work_q[WIDTH-1:0], 1'b1};
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    state_d  = END;
                    ready_d  = 1'b1;
                    result_d = {rem, quo};
                end
            end
            END: begin
                ready_d = 1'b1;
                if (!start_i) begin
                    state_d  = IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end
            default: begin
                state_d  = IDLE;
                ready_d  = 1'b0;
                result_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            work_q   <= '0;
            dvsr_q   <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            dvsr_q   <= dvsr_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results,
// divide-by-zero, annul, reset abort and operand isolation.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    int checks = 0;
    int errors = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_ready(input string tag, input int lat,
                              input logic [63:0] exp);
        int n;
        n = 0;
        while (n < 60) begin
            step();
            n++;
            if (ready_o === 1'b1) break;
        end
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " result"}, result_o, exp);
    endtask

    task automatic do_div(input string tag, input logic sg,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat);
        signed_div_i = sg;
        opdata1_i = a;
        opdata2_i = b;
        start_i = 1'b1;
        wait_ready(tag, lat, exp);
        annul_i = 1'b1;
        step();
        annul_i = 1'b0;
        check({tag, " hold rdy"}, 64'(ready_o), 64'd1);
        check({tag, " hold res"}, result_o, exp);
        start_i = 1'b0;
        step();
        check({tag, " drop rdy"}, 64'(ready_o), 64'd0);
        check({tag, " drop res"}, result_o, 64'd0);
    endtask

    initial begin
        step();
        step();
        check("reset rdy", 64'(ready_o), 64'd0);
        check("reset res", result_o, 64'd0);
        rst = 1'b0;
        step();
        check("idle rdy", 64'(ready_o), 64'd0);

        do_div("divu 100/7", 1'b0, 32'd100, 32'd7,
               {32'd2, 32'd14}, 34);
        do_div("div -7/2", 1'b1, 32'hFFFFFFF9, 32'd2,
               {32'hFFFFFFFF, 32'hFFFFFFFD}, 34);
        do_div("div 7/-2", 1'b1, 32'd7, 32'hFFFFFFFE,
               {32'd1, 32'hFFFFFFFD}, 34);
        do_div("divu x/0", 1'b0, 32'd55, 32'd0, 64'd0, 2);
        do_div("div -9/0", 1'b1, 32'hFFFFFFF7, 32'd0, 64'd0, 2);
        do_div("div ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF,
               {32'd0, 32'h80000000}, 34);
        do_div("divu big", 1'b0, 32'h80000000, 32'hFFFFFFFF,
               {32'h80000000, 32'd0}, 34);
        do_div("divu 1000/1000", 1'b0, 32'd1000, 32'd1000,
               {32'd0, 32'd1}, 34);

        // Annul sampled on edge 10 of an unsigned divide.
        signed_div_i = 1'b0;
        opdata1_i = 32'd12345;
        opdata2_i = 32'd17;
        start_i = 1'b1;
        repeat (9) step();
        annul_i = 1'b1;
        start_i = 1'b0;
        step();
        annul_i = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 40; i++) begin
                if (ready_o !== 1'b0) seen++;
                step();
            end
            check("annul no rdy", 64'(seen), 64'd0);
        end
        check("annul res", result_o, 64'd0);
        do_div("after annul", 1'b0, 32'hFFFFFFFF, 32'd1,
               {32'd0, 32'hFFFFFFFF}, 34);

        // Reset sampled on edge 20 of a divide.
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i = 1'b1;
        repeat (19) step();
        rst = 1'b1;
        start_i = 1'b0;
        step();
        check("rst rdy", 64'(ready_o), 64'd0);
        check("rst res", result_o, 64'd0);
        rst = 1'b0;
        repeat (20) step();
        check("rst idle rdy", 64'(ready_o), 64'd0);

        // Operand changes after accept must not affect the result.
        signed_div_i = 1'b0;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i = 1'b1;
        step();
        opdata1_i = 32'd9;
        opdata2_i = 32'd0;
        signed_div_i = 1'b1;
        wait_ready("latched ops", 33, {32'd2, 32'd14});
        start_i = 1'b0;
        step();
        check("latched drop", 64'(ready_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
